// File: rtl/sram_mem_ctrl.sv
// Data-memory responder: serves 32-bit MA-stage word requests from a 16-bit
// asynchronous SRAM as two half-word cycles with programmable wait states.
module sram_mem_ctrl #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        data,
  output logic [31:0]        mem_result,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int          CW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-2:0] wi_q;
  logic [31:0]        data_q;
  logic               is_wr;
  logic [31:0]        rd;

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] wi;
  logic               unused_bits;
  logic               req;

  // Byte offset from the SRAM base; high bits wrap silently, low bits are the byte lane.
  assign offset      = address - BASE_ADDR;
  assign wi          = offset[SRAM_AW:2];
  assign unused_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign req         = mem_r_en | mem_w_en;

  assign ready      = (state == DONE) || ((state == IDLE) && !req);
  assign mem_result = ((state == DONE) && !is_wr) ? rd : 32'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wi_q       <= '0;
      data_q     <= '0;
      is_wr      <= 1'b0;
      rd         <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            wi_q       <= wi;
            data_q     <= data;
            is_wr      <= mem_w_en;
            cnt        <= RELOAD;
            state      <= LO;
            sram_addr  <= {wi, 1'b0};
            sram_wdata <= mem_w_en ? data[15:0] : 16'b0;
            sram_we_n  <= ~mem_w_en;
            sram_oe_n  <= mem_w_en;
          end
        end
        LO: begin
          if (cnt == '0) begin
            cnt        <= RELOAD;
            state      <= HI;
            sram_addr  <= {wi_q, 1'b1};
            sram_wdata <= is_wr ? data_q[31:16] : 16'b0;
            if (!is_wr) rd[15:0] <= sram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI: begin
          if (cnt == '0) begin
            state      <= DONE;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            if (!is_wr) rd[31:16] <= sram_rdata;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
